// File: rtl/memory_router_if.sv
// Bus bundle shared by the arbiter's memory port, the memory router and the
// clint/print/bram slaves. The router sits on the "slave" modport.
interface memory_router_if;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;
    logic        memory_error;
    logic [2:0]  slave_valid;
    logic        slave_instr;
    logic [31:0] slave_addr;
    logic [31:0] slave_wdata;
    logic [3:0]  slave_wstrb;
    logic [95:0] slave_rdata;
    logic [2:0]  slave_ready;

    modport slave (
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        output memory_rdata, memory_ready, memory_error,
        output slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
        input  slave_rdata, slave_ready
    );

    modport master (
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        input  memory_rdata, memory_ready, memory_error,
        input  slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
        output slave_rdata, slave_ready
    );
endinterface

// File: rtl/memory_router.sv
// Sequencing bus controller: registers one request, routes it to clint/print/bram
// with base-relative addressing, and answers with the slave data or an error.

module memory_router_chk (
    input logic i_clock,
    input logic i_reset,
    input logic i_memory_valid,
    input logic i_can_accept
);
    // The arbiter must hold off until memory_ready; a strobe while busy is dropped.
    a_no_strobe_while_busy: assert property (
        @(posedge i_clock) disable iff (!i_reset) i_memory_valid |-> i_can_accept
    ) else $error("memory_router: memory_valid while busy, request dropped");
endmodule

module memory_router #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_TOP  = 32'h0200_C000,
    parameter logic [31:0] PRINT_BASE = 32'h1000_0000,
    parameter logic [31:0] PRINT_TOP  = 32'h1000_1000,
    parameter logic [31:0] BRAM_BASE  = 32'h8000_0000,
    parameter logic [31:0] BRAM_TOP   = 32'h8010_0000,
    parameter logic [31:0] HOST_ADDR  = 32'h8000_1000,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic           clock,
    input  logic           reset,
    memory_router_if.slave bus,
    output logic [15:0]    error_count
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_RESP_ERR = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_sel;
    logic [15:0] r_count;
    logic [2:0]  r_slave_valid;
    logic        r_slave_instr;
    logic [31:0] r_slave_addr;
    logic [31:0] r_slave_wdata;
    logic [3:0]  r_slave_wstrb;
    logic        r_mem_ready;
    logic        r_mem_error;
    logic [31:0] r_mem_rdata;
    logic [15:0] r_error_count;

    logic        w_mapped;
    logic [1:0]  w_dec_sel;
    logic [31:0] w_dec_base;
    logic        w_can_accept;
    logic        w_accept;
    logic        w_sel_ready;
    logic [31:0] w_sel_rdata;
    logic        w_timeout;
    logic [2:0]  w_slave_valid;
    logic        w_mem_ready;
    logic        w_mem_error;
    logic [31:0] w_mem_rdata;

    // Priority decode: clint > print > bram > tohost word (bram) > unmapped.
    always_comb begin
        w_mapped   = 1'b1;
        w_dec_sel  = 2'd0;
        w_dec_base = CLINT_BASE;
        if (bus.memory_addr >= CLINT_BASE && bus.memory_addr < CLINT_TOP) begin
            w_dec_sel  = 2'd0;
            w_dec_base = CLINT_BASE;
        end else if (bus.memory_addr >= PRINT_BASE && bus.memory_addr < PRINT_TOP) begin
            w_dec_sel  = 2'd1;
            w_dec_base = PRINT_BASE;
        end else if (bus.memory_addr >= BRAM_BASE && bus.memory_addr < BRAM_TOP) begin
            w_dec_sel  = 2'd2;
            w_dec_base = BRAM_BASE;
        end else if (bus.memory_addr == HOST_ADDR) begin
            w_dec_sel  = 2'd2;
            w_dec_base = BRAM_BASE;
        end else begin
            w_mapped   = 1'b0;
            w_dec_sel  = 2'd0;
            w_dec_base = 32'h0000_0000;
        end
    end

    // The memory_ready cycle is still busy even though the state is already IDLE.
    assign w_can_accept = (r_state == S_IDLE) && !r_mem_ready;
    assign w_accept     = w_can_accept && bus.memory_valid;
    assign w_timeout    = (r_count == TIMEOUT_LAST);

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = 32'h0000_0000;
        case (r_sel)
            2'd0: begin
                w_sel_ready = bus.slave_ready[0];
                w_sel_rdata = bus.slave_rdata[31:0];
            end
            2'd1: begin
                w_sel_ready = bus.slave_ready[1];
                w_sel_rdata = bus.slave_rdata[63:32];
            end
            2'd2: begin
                w_sel_ready = bus.slave_ready[2];
                w_sel_rdata = bus.slave_rdata[95:64];
            end
            default: begin
                w_sel_ready = 1'b0;
                w_sel_rdata = 32'h0000_0000;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready beats timeout when both occur in the same WAIT cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_mapped ? S_WAIT : S_RESP_ERR;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_sel_ready) begin
                    w_next_state = S_IDLE;
                end else if (w_timeout) begin
                    w_next_state = S_RESP_ERR;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_RESP_ERR: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_slave_valid = 3'b000;
        w_mem_ready   = 1'b0;
        w_mem_error   = 1'b0;
        w_mem_rdata   = 32'h0000_0000;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_mapped) begin
                    w_slave_valid = 3'b001 << w_dec_sel;
                end else begin
                    w_slave_valid = 3'b000;
                end
            end
            S_WAIT: begin
                if (w_sel_ready) begin
                    w_mem_ready = 1'b1;
                    w_mem_rdata = w_sel_rdata;
                end else begin
                    w_mem_ready = 1'b0;
                end
            end
            S_RESP_ERR: begin
                w_mem_ready = 1'b1;
                w_mem_error = 1'b1;
            end
            default: begin
                w_mem_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_slave_valid <= 3'b000;
            r_mem_ready   <= 1'b0;
            r_mem_error   <= 1'b0;
            r_mem_rdata   <= 32'h0000_0000;
            r_error_count <= 16'h0000;
        end else begin
            r_slave_valid <= w_slave_valid;
            r_mem_ready   <= w_mem_ready;
            r_mem_error   <= w_mem_error;
            r_mem_rdata   <= w_mem_rdata;
            if (w_mem_error && r_error_count != 16'hFFFF) begin
                r_error_count <= r_error_count + 16'd1;
            end
        end
    end

    // Request fields are held until the next accepted request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sel         <= 2'd0;
            r_count       <= 16'h0000;
            r_slave_instr <= 1'b0;
            r_slave_addr  <= 32'h0000_0000;
            r_slave_wdata <= 32'h0000_0000;
            r_slave_wstrb <= 4'h0;
        end else begin
            if (w_accept && w_mapped) begin
                r_sel         <= w_dec_sel;
                r_slave_instr <= bus.memory_instr;
                r_slave_addr  <= bus.memory_addr - w_dec_base;
                r_slave_wdata <= bus.memory_wdata;
                r_slave_wstrb <= bus.memory_wstrb;
            end
            if (w_accept) begin
                r_count <= 16'h0000;
            end else if (r_state == S_WAIT && !w_sel_ready && !w_timeout) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign bus.slave_valid  = r_slave_valid;
    assign bus.slave_instr  = r_slave_instr;
    assign bus.slave_addr   = r_slave_addr;
    assign bus.slave_wdata  = r_slave_wdata;
    assign bus.slave_wstrb  = r_slave_wstrb;
    assign bus.memory_ready = r_mem_ready;
    assign bus.memory_error = r_mem_error;
    assign bus.memory_rdata = r_mem_rdata;
    assign error_count      = r_error_count;

    memory_router_chk u_chk (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_memory_valid (bus.memory_valid),
        .i_can_accept   (w_can_accept)
    );
endmodule

// File: tb/tb_memory_router.sv
// Randomized scoreboard bench for memory_router: a driver pushes expectations
// from an address-map model, a negedge monitor pops and compares.
module tb_memory_router;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_TOP  = 32'h0200_C000;
    localparam logic [31:0] PRINT_BASE = 32'h1000_0000;
    localparam logic [31:0] PRINT_TOP  = 32'h1000_1000;
    localparam logic [31:0] BRAM_BASE  = 32'h8000_0000;
    localparam logic [31:0] BRAM_TOP   = 32'h8010_0000;
    localparam logic [31:0] HOST_ADDR  = 32'h8000_1000;
    localparam int          TB_TIMEOUT = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] error_count;

    memory_router_if bus();

    memory_router #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .error_count (error_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  onehot;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } slv_exp_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
        logic        err;
        logic [15:0] ecnt;
    } rsp_exp_t;

    slv_exp_t    slv_q[$];
    rsp_exp_t    rsp_q[$];
    slv_exp_t    mon_s;
    rsp_exp_t    mon_r;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] model_err = 16'h0000;
    logic [31:0] held_addr = 32'h0000_0000;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Address map model: half-open windows, lowest slave index wins, then tohost.
    function automatic void model_decode(input logic [31:0] a, output bit mapped,
                                         output int sel, output logic [31:0] off);
        logic [31:0] lo [3];
        logic [31:0] hi [3];
        lo[0] = CLINT_BASE; hi[0] = CLINT_TOP;
        lo[1] = PRINT_BASE; hi[1] = PRINT_TOP;
        lo[2] = BRAM_BASE;  hi[2] = BRAM_TOP;
        mapped = 1'b0;
        sel    = 0;
        off    = 32'h0;
        for (int i = 2; i >= 0; i--) begin
            if (a >= lo[i] && a < hi[i]) begin
                mapped = 1'b1;
                sel    = i;
                off    = a - lo[i];
            end
        end
        if (!mapped && a == HOST_ADDR) begin
            mapped = 1'b1;
            sel    = 2;
            off    = a - BRAM_BASE;
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [8];
        edges[0] = CLINT_TOP - 32'd1; edges[1] = CLINT_TOP;
        edges[2] = CLINT_BASE - 32'd1; edges[3] = PRINT_TOP - 32'd1;
        edges[4] = PRINT_TOP; edges[5] = BRAM_TOP - 32'd4;
        edges[6] = BRAM_TOP; edges[7] = BRAM_BASE - 32'd1;
        case ($urandom_range(0, 7))
            0:       return CLINT_BASE + ($urandom() % (CLINT_TOP - CLINT_BASE));
            1:       return PRINT_BASE + ($urandom() % (PRINT_TOP - PRINT_BASE));
            2, 3:    return BRAM_BASE + ($urandom() % (BRAM_TOP - BRAM_BASE));
            4:       return HOST_ADDR;
            5:       return $urandom();
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    // Issues one request, plays the slave side (delay<0: never ready) with noise
    // on the other ready lines, and returns in the cycle after memory_ready.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr,
                           input int delay, input logic [31:0] rdata);
        bit          mapped;
        int          sel;
        logic [31:0] off;
        int unsigned n;
        int unsigned rc;
        logic [2:0]  own;
        slv_exp_t    s;
        rsp_exp_t    r;
        model_decode(addr, mapped, sel, off);
        n   = cyc;
        own = mapped ? 3'(1 << sel) : 3'b000;
        bus.memory_valid = 1'b1;
        bus.memory_addr  = addr;
        bus.memory_wdata = wdata;
        bus.memory_wstrb = wstrb;
        bus.memory_instr = instr;
        if (mapped) begin
            s.cyc = n + 1; s.onehot = own; s.addr = off;
            s.wdata = wdata; s.wstrb = wstrb; s.instr = instr;
            slv_q.push_back(s);
        end
        if (!mapped || delay < 0) begin
            rc = mapped ? n + TB_TIMEOUT + 2 : n + 2;
            if (model_err != 16'hFFFF) model_err = model_err + 16'd1;
            r.rdata = 32'h0;
            r.err   = 1'b1;
        end else begin
            rc      = n + 2 + int'(delay);
            r.rdata = rdata;
            r.err   = 1'b0;
        end
        r.cyc  = rc;
        r.ecnt = model_err;
        rsp_q.push_back(r);
        next_cycle();
        bus.memory_valid = 1'b0;
        bus.memory_addr  = $urandom();
        while (cyc < rc) begin
            bus.slave_rdata = {$urandom(), $urandom(), $urandom()};
            if (mapped && delay >= 0 && int'(cyc - n - 1) == delay) begin
                bus.slave_ready = own;
                bus.slave_rdata[32*sel +: 32] = rdata;
            end else begin
                bus.slave_ready = 3'($urandom_range(0, 7)) & ~own;
            end
            next_cycle();
        end
        bus.slave_ready = 3'b000;
        next_cycle();
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("reset_outputs",
                  64'({bus.slave_valid, bus.slave_instr, bus.memory_ready, bus.memory_error,
                       bus.slave_wstrb, error_count,
                       bus.memory_rdata | bus.slave_addr | bus.slave_wdata}), 64'h0);
        end else begin
            if (bus.slave_valid != 3'b000) begin
                if (slv_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_slave_valid: got %b expected none (cycle %0d)",
                             bus.slave_valid, cyc);
                end else begin
                    mon_s = slv_q.pop_front();
                    check("slave_valid_cycle", 64'(cyc), 64'(mon_s.cyc));
                    check("slave_valid", 64'(bus.slave_valid), 64'(mon_s.onehot));
                    check("slave_addr", 64'(bus.slave_addr), 64'(mon_s.addr));
                    check("slave_wdata", 64'(bus.slave_wdata), 64'(mon_s.wdata));
                    check("slave_wstrb", 64'(bus.slave_wstrb), 64'(mon_s.wstrb));
                    check("slave_instr", 64'(bus.slave_instr), 64'(mon_s.instr));
                    held_addr = mon_s.addr;
                end
            end else begin
                check("slave_addr_hold", 64'(bus.slave_addr), 64'(held_addr));
            end
            if (bus.memory_ready) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_memory_ready: got ready expected none (cycle %0d)", cyc);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("resp_cycle", 64'(cyc), 64'(mon_r.cyc));
                    check("resp_rdata", 64'(bus.memory_rdata), 64'(mon_r.rdata));
                    check("resp_error", 64'(bus.memory_error), 64'(mon_r.err));
                    check("error_count", 64'(error_count), 64'(mon_r.ecnt));
                end
            end else begin
                check("idle_rdata_error", 64'({bus.memory_error, bus.memory_rdata}), 64'h0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at 1 ms, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        slv_exp_t    s;
        int unsigned n;
        reset            = 1'b1;
        bus.memory_valid = 1'b0;
        bus.memory_instr = 1'b0;
        bus.memory_addr  = 32'h0;
        bus.memory_wdata = 32'h0;
        bus.memory_wstrb = 4'h0;
        bus.slave_rdata  = 96'h0;
        bus.slave_ready  = 3'b000;
        #1 reset = 1'b0;
        repeat (3) next_cycle();
        reset = 1'b1;
        next_cycle();

        run_txn(32'h8000_0010, 32'h0, 4'h0, 1'b0, 1, 32'hDEAD_BEEF);
        run_txn(32'h1000_0000, 32'h41, 4'b0001, 1'b0, 1, 32'h0);
        run_txn(HOST_ADDR, 32'h0, 4'h0, 1'b0, 1, 32'h1234_5678);
        run_txn(32'h0200_4000, 32'h0, 4'h0, 1'b1, 2, 32'h0BAD_F00D);
        run_txn(32'h0000_0000, 32'h0, 4'h0, 1'b0, 1, 32'h5555_5555);
        run_txn(32'h0200_0008, 32'h0, 4'h0, 1'b0, -1, 32'h0);
        bus.slave_ready = 3'b001;
        next_cycle();
        bus.slave_ready = 3'b000;
        repeat (2) next_cycle();

        for (int i = 0; i < 150; i++) begin
            run_txn(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), $urandom());
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        n = cyc;
        bus.memory_valid = 1'b1;
        bus.memory_addr  = BRAM_BASE + 32'h40;
        bus.memory_wdata = 32'h0;
        bus.memory_wstrb = 4'h0;
        bus.memory_instr = 1'b0;
        s.cyc = n + 1; s.onehot = 3'b100; s.addr = 32'h40;
        s.wdata = 32'h0; s.wstrb = 4'h0; s.instr = 1'b0;
        slv_q.push_back(s);
        next_cycle();
        bus.memory_valid = 1'b0;
        repeat (4) next_cycle();
        reset = 1'b0;
        slv_q.delete();
        rsp_q.delete();
        model_err = 16'h0000;
        held_addr = 32'h0000_0000;
        repeat (3) next_cycle();
        reset = 1'b1;
        bus.slave_ready = 3'b100;
        next_cycle();
        bus.slave_ready = 3'b000;
        next_cycle();
        run_txn(BRAM_BASE + 32'h200, 32'h0, 4'h0, 1'b0, 1, 32'hCAFE_F00D);
        repeat (3) next_cycle();

        check("slave_queue_drained", 64'(slv_q.size()), 64'h0);
        check("resp_queue_drained", 64'(rsp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
